// File: rtl/rv523_muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// rv523_muldiv_seq_if
//   Request/response bundle between the execute stage and the iterative
//   RV32M multiply/divide unit.
//   Request  : req_valid, req_ready, req_op (funct3), req_a (rs1), req_b (rs2)
//   Response : resp_valid, resp_ready, resp_data
//   master = issuing pipeline side, slave = muldiv unit.
// ---------------------------------------------------------------------------
interface rv523_muldiv_seq_if #(
    parameter int XLEN = 32
) ();
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/rv523_muldiv_seq.sv
// ---------------------------------------------------------------------------
// rv523_muldiv_seq
//   Iterative RV32M multiply/divide, one bit per cycle on a shared
//   XLEN+1 bit adder. Shift-add multiply, restoring divide.
//   Ports:
//     i_clk    system clock, rising edge
//     i_nrst   synchronous active-low reset
//     i_kill   pipeline flush, abandons any operation in flight
//     if_bus   request/response handshake (slave side)
//     o_busy   unit not idle
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a request; req_ready high
//   CALC   | one multiply/divide step per cycle, XLEN steps
//   FIX    | apply result sign, select output, register resp_data
//   DONE   | resp_valid held until resp_ready
// ---------------------------------------------------------------------------
module rv523_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,
    input  logic                    i_kill,
    rv523_muldiv_seq_if.slave       if_bus,
    output logic                    o_busy
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            r_state;
    logic [2:0]        r_op;
    logic              r_sa;
    logic              r_sb;
    logic              r_dz;
    logic [XLEN-1:0]   r_m;
    logic [2*XLEN-1:0] r_p;
    logic [CW-1:0]     r_cnt;
    logic              r_resp_valid;
    logic [XLEN-1:0]   r_resp_data;
    logic              r_busy;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa_in;
    logic              w_sb_in;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div;
    logic [XLEN-1:0]   w_p_hi;
    logic [XLEN:0]     w_add_lhs;
    logic [XLEN:0]     w_add_rhs;
    logic [XLEN:0]     w_add_sum;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem_src;
    logic [XLEN-1:0]   w_fix_data;

    assign w_req_ready = (r_state == S_IDLE) && !i_kill && i_nrst;
    assign w_accept    = if_bus.req_valid && w_req_ready;

    // Signed operands are latched as magnitudes; the most-negative value
    // negates to itself, which reads correctly as unsigned 2^(XLEN-1).
    assign w_a_signed = (if_bus.req_op == 3'd1) || (if_bus.req_op == 3'd2) ||
                        (if_bus.req_op == 3'd4) || (if_bus.req_op == 3'd6);
    assign w_b_signed = (if_bus.req_op == 3'd1) || (if_bus.req_op == 3'd4) ||
                        (if_bus.req_op == 3'd6);
    assign w_sa_in    = w_a_signed && if_bus.req_a[XLEN-1];
    assign w_sb_in    = w_b_signed && if_bus.req_b[XLEN-1];
    assign w_a_mag    = w_sa_in ? (~if_bus.req_a + XLEN'(1)) : if_bus.req_a;
    assign w_b_mag    = w_sb_in ? (~if_bus.req_b + XLEN'(1)) : if_bus.req_b;

    // Shared adder: multiply adds the multiplicand into the high half;
    // divide subtracts the divisor from the shifted partial remainder.
    assign w_div     = r_op[2];
    assign w_p_hi    = r_p[2*XLEN-1:XLEN];
    assign w_add_lhs = w_div ? {w_p_hi, r_p[XLEN-1]} : {1'b0, w_p_hi};
    assign w_add_rhs = w_div ? ~{1'b0, r_m} : {1'b0, r_m};
    assign w_add_sum = w_add_lhs + w_add_rhs + {{XLEN{1'b0}}, w_div};

    // Partial remainder stays below the divisor, so the sign bit of the
    // XLEN+1 bit difference is a reliable "does not fit" flag.
    always_comb begin
        w_step = r_p;
        if (w_div) begin
            if (w_add_sum[XLEN])
                w_step = {w_add_lhs[XLEN-1:0], r_p[XLEN-2:0], 1'b0};
            else
                w_step = {w_add_sum[XLEN-1:0], r_p[XLEN-2:0], 1'b1};
        end else begin
            if (r_p[0])
                w_step = {w_add_sum, r_p[XLEN-1:1]};
            else
                w_step = {1'b0, w_p_hi, r_p[XLEN-1:1]};
        end
    end

    // On a zero divisor the dividend magnitude is still in the low half.
    assign w_prod    = (r_sa ^ r_sb) ? (~r_p + (2*XLEN)'(1)) : r_p;
    assign w_quo     = (r_sa ^ r_sb) ? (~r_p[XLEN-1:0] + XLEN'(1)) : r_p[XLEN-1:0];
    assign w_rem_src = r_dz ? r_p[XLEN-1:0] : w_p_hi;

    always_comb begin
        w_fix_data = '0;
        case (r_op)
            3'd0:                   w_fix_data = r_p[XLEN-1:0];
            3'd1, 3'd2, 3'd3:       w_fix_data = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:             w_fix_data = r_dz ? '1 : w_quo;
            default:                w_fix_data = r_sa ? (~w_rem_src + XLEN'(1)) : w_rem_src;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_dz         <= 1'b0;
            r_m          <= '0;
            r_p          <= '0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_busy       <= 1'b0;
        end else if (i_kill) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= if_bus.req_op;
                        r_sa    <= w_sa_in;
                        r_sb    <= w_sb_in;
                        r_dz    <= if_bus.req_op[2] && (if_bus.req_b == '0);
                        r_m     <= w_b_mag;
                        r_p     <= {{XLEN{1'b0}}, w_a_mag};
                        r_cnt   <= CW'(XLEN);
                        r_busy  <= 1'b1;
                        r_state <= (if_bus.req_op[2] && (if_bus.req_b == '0)) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r_p   <= w_step;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_resp_data  <= w_fix_data;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    if (if_bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_bus.req_ready  = w_req_ready;
    assign if_bus.resp_valid = r_resp_valid;
    assign if_bus.resp_data  = r_resp_data;
    assign o_busy            = r_busy;

endmodule

// File: tb/tb_rv523_muldiv_seq.sv
module tb_rv523_muldiv_seq;
    localparam int XLEN = 32;

    logic clk;
    logic nrst;
    logic kill;
    logic busy;
    int   n_checks;
    int   n_errors;

    rv523_muldiv_seq_if #(.XLEN(XLEN)) bus ();

    rv523_muldiv_seq #(.XLEN(XLEN)) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .i_kill (kill),
        .if_bus (bus),
        .o_busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural RV32M results from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa;
        longint     sb;
        longint     ua;
        longint     ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Presents a request and returns once the accepting edge has passed;
    // the request fields are then scrambled since the unit must have latched them.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int w;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.resp_ready = 1'b0;
        w = 0;
        while (!bus.req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check_val("req_ready_timeout", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom);
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
    endtask

    // Waits for resp_valid, holds it off for bp cycles, then takes it.
    task automatic finish_op(input string tag, input int bp, input logic [31:0] exp_data, input int exp_lat);
        int          lat;
        logic [31:0] data;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.resp_valid && lat < 200);
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        data = bus.resp_data;
        check_val({tag, "_data"}, 64'(data), 64'(exp_data));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check_val({tag, "_hold_data"}, 64'(bus.resp_data), 64'(data));
            check_val({tag, "_hold_valid"}, 64'(bus.resp_valid), 64'd1);
            check_val({tag, "_hold_rdy"}, 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check_val({tag, "_post_valid"}, 64'(bus.resp_valid), 64'd0);
        check_val({tag, "_post_rdy"}, 64'(bus.req_ready), 64'd1);
    endtask

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] b);
        return (op[2] && b == 32'd0) ? 2 : XLEN + 2;
    endfunction

    logic [2:0]  d_op  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd4, 3'd6, 3'd6, 3'd5};
    logic [31:0] d_a   [10] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5,
                                32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'd100};
    logic [31:0] d_b   [10] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd7};
    logic [31:0] d_exp [10] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                32'h00000005, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'd14};

    initial begin
        int          seen;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        n_checks       = 0;
        n_errors       = 0;
        nrst           = 1'b0;
        kill           = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_val("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_val("rst_resp_data", 64'(bus.resp_data), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
        nrst = 1'b1;
        @(negedge clk);
        check_val("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

        // Directed cases with hand-computed results.
        for (int i = 0; i < 10; i++) begin
            start_op(d_op[i], d_a[i], d_b[i]);
            check_val("directed_busy", 64'(busy), 64'd1);
            finish_op($sformatf("dir%0d", i), 0, d_exp[i], exp_latency(d_op[i], d_b[i]));
        end

        // Backpressure in DONE.
        start_op(3'd5, 32'd1000, 32'd33);
        finish_op("bp", 5, 32'd30, XLEN + 2);

        // Kill during CALC: the result must never appear.
        start_op(3'd0, 32'h12345678, 32'h9ABCDEF0);
        repeat (10) @(negedge clk);
        kill = 1'b1;
        check_val("kill_rdy_low", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        check_val("kill_req_ready", 64'(bus.req_ready), 64'd1);
        check_val("kill_busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < XLEN + 8; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check_val("kill_no_resp", 64'(seen), 64'd0);
        start_op(3'd3, 32'hDEADBEEF, 32'hCAFEF00D);
        finish_op("after_kill", 0, ref_model(3'd3, 32'hDEADBEEF, 32'hCAFEF00D), XLEN + 2);

        // Reset pulse mid-CALC clears everything, including resp_data.
        start_op(3'd1, 32'h7FFFFFFF, 32'h80000001);
        repeat (6) @(negedge clk);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        check_val("mid_rst_valid", 64'(bus.resp_valid), 64'd0);
        check_val("mid_rst_data", 64'(bus.resp_data), 64'd0);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        check_val("mid_rst_rdy", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("mid_rst_rdy_after", 64'(bus.req_ready), 64'd1);
        start_op(3'd6, 32'hFFFFFF00, 32'd7);
        finish_op("after_rst", 0, ref_model(3'd6, 32'hFFFFFF00, 32'd7), XLEN + 2);

        // Random operations with corner-value operands mixed in.
        for (int i = 0; i < 120; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            start_op(op, a, b);
            finish_op($sformatf("rnd%0d_op%0d", i, op), $urandom_range(0, 2),
                      ref_model(op, a, b), exp_latency(op, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
